// File: rtl/vertex_sched.sv
// Streaming sequencer around one vertex_processor: loads info words, runs the
// program for a configured cycle count, reads back the result word.
module vertex_sched #(
  parameter int                     info_w        = 128,
  parameter int                     info__add_W   = 8,
  parameter int                     pc_ins_addr_w = 8,
  parameter int                     ins_data_w    = 15,
  parameter int                     WORDS         = 4,
  parameter logic [info__add_W-1:0] INFO_BASE     = '0,
  parameter logic [info__add_W-1:0] RES_ADDR      = {info__add_W{1'b1}}
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               cfg_prog_len,
  input  logic                     host_we,
  input  logic [pc_ins_addr_w-1:0] host_addr,
  input  logic [ins_data_w-1:0]    host_din,
  output logic                     host_busy,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [info_w-1:0]        in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [info_w-1:0]        out_data,
  output logic [15:0]              vert_count,
  output logic                     vp_enable,
  output logic                     vp_reset,
  output logic                     vp_we_ins_m,
  output logic [pc_ins_addr_w-1:0] vp_addr_ins_m,
  output logic [ins_data_w-1:0]    vp_din_ins_m,
  output logic                     vp_we_inf,
  output logic [info__add_W-1:0]   vp_addr_inf,
  output logic [info_w-1:0]        vp_info_in,
  input  logic [info_w-1:0]        vp_vert_out
);

  // state  | meaning
  // IDLE   | host may write instruction memory; waits for a vertex
  // LOAD   | accepts WORDS info beats into data memory
  // CLEAR  | one cycle of processor PC reset, run counter loaded
  // RUN    | processor enabled for cfg_prog_len cycles
  // READ_A | result address presented to data memory
  // READ_C | result word captured into out_data
  // OUT    | result offered downstream
  typedef enum logic [2:0] {IDLE, LOAD, CLEAR, RUN, READ_A, READ_C, OUT} state_t;

  state_t     state, state_nx;
  logic [7:0] idx;
  logic [7:0] run_cnt;
  logic       beat, idx_clr, cnt_load;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      idx        <= '0;
      run_cnt    <= '0;
      out_data   <= '0;
      vert_count <= '0;
    end else begin
      if (idx_clr)   idx <= '0;
      else if (beat) idx <= idx + 8'd1;
      if (cnt_load)          run_cnt <= cfg_prog_len;
      else if (state == RUN) run_cnt <= run_cnt - 8'd1;
      if (state == READ_C) out_data <= vp_vert_out;
      if (out_valid && out_ready) vert_count <= vert_count + 16'd1;
    end
  end

  always_comb begin
    state_nx    = state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    vp_enable   = 1'b0;
    vp_reset    = !reset;
    vp_we_inf   = 1'b0;
    vp_addr_inf = INFO_BASE;
    vp_info_in  = in_data;
    vp_we_ins_m = 1'b0;
    beat        = 1'b0;
    idx_clr     = 1'b0;
    cnt_load    = 1'b0;
    case (state)
      IDLE: begin
        vp_we_ins_m = host_we;
        if (!host_we && in_valid) begin
          state_nx = LOAD;
          idx_clr  = 1'b1;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          beat        = 1'b1;
          vp_we_inf   = 1'b1;
          vp_addr_inf = INFO_BASE + info__add_W'(idx);
          if (idx == 8'(WORDS - 1)) state_nx = CLEAR;
        end
      end
      CLEAR: begin
        vp_reset = 1'b1;
        cnt_load = 1'b1;
        state_nx = (cfg_prog_len != 8'd0) ? RUN : READ_A;
      end
      RUN: begin
        vp_enable = 1'b1;
        if (run_cnt == 8'd1) state_nx = READ_A;
      end
      READ_A: begin
        vp_addr_inf = RES_ADDR;
        state_nx    = READ_C;
      end
      READ_C: begin
        vp_addr_inf = RES_ADDR;
        state_nx    = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // while reset is held the processor is halted and no handshake or write escapes
    if (!reset) begin
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      vp_enable   = 1'b0;
      vp_we_inf   = 1'b0;
      vp_we_ins_m = 1'b0;
    end
  end

  assign host_busy     = (state != IDLE);
  assign vp_addr_ins_m = host_addr;
  assign vp_din_ins_m  = host_din;

endmodule

// File: tb/tb_vertex_sched.sv
// Directed bench for vertex_sched with a small synchronous data-memory model
// standing in for the processor's info port.
module tb_vertex_sched;
  localparam int WORDS = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   cfg_prog_len;
  logic         host_we;
  logic [7:0]   host_addr;
  logic [14:0]  host_din;
  logic         host_busy;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [15:0]  vert_count;
  logic         vp_enable, vp_reset, vp_we_ins_m, vp_we_inf;
  logic [7:0]   vp_addr_ins_m;
  logic [14:0]  vp_din_ins_m;
  logic [7:0]   vp_addr_inf;
  logic [127:0] vp_info_in;
  logic [127:0] vp_vert_out = '0;

  logic [127:0] mem [256];
  logic [127:0] res_val = '0;
  int           vec   = 0;
  int           fails = 0;
  logic [15:0]  exp_cnt = '0;

  always #5 clk = ~clk;

  vertex_sched #(.WORDS(WORDS)) dut (
    .clk(clk), .reset(reset), .cfg_prog_len(cfg_prog_len),
    .host_we(host_we), .host_addr(host_addr), .host_din(host_din), .host_busy(host_busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .vert_count(vert_count),
    .vp_enable(vp_enable), .vp_reset(vp_reset), .vp_we_ins_m(vp_we_ins_m),
    .vp_addr_ins_m(vp_addr_ins_m), .vp_din_ins_m(vp_din_ins_m),
    .vp_we_inf(vp_we_inf), .vp_addr_inf(vp_addr_inf), .vp_info_in(vp_info_in),
    .vp_vert_out(vp_vert_out)
  );

  // one-cycle synchronous read; the result address returns the per-vertex result word
  always @(posedge clk) begin
    if (vp_we_inf) mem[vp_addr_inf] <= vp_info_in;
    vp_vert_out <= (vp_addr_inf == 8'hFF) ? res_val : mem[vp_addr_inf];
  end

  task automatic test_reset();
    reset = 1'b0; cfg_prog_len = 8'd0; host_we = 1'b0; host_addr = '0; host_din = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    vec++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    vec++; if (out_data !== '0) begin fails++; $display("FAIL rst_out_data got %h want 0", out_data); end
    vec++; if (vert_count !== 16'd0) begin fails++; $display("FAIL rst_vert_count got %0d want 0", vert_count); end
    vec++; if (in_ready !== 1'b0 || vp_enable !== 1'b0) begin fails++; $display("FAIL rst_ready_enable got %b%b want 00", in_ready, vp_enable); end
    vec++; if (vp_we_inf !== 1'b0 || vp_we_ins_m !== 1'b0) begin fails++; $display("FAIL rst_we got %b%b want 00", vp_we_inf, vp_we_ins_m); end
    vec++; if (host_busy !== 1'b0) begin fails++; $display("FAIL rst_host_busy got %b want 0", host_busy); end
    vec++; if (vp_reset !== 1'b1) begin fails++; $display("FAIL rst_vp_reset_held got %b want 1", vp_reset); end
    reset = 1'b1;
    @(negedge clk); #1;
    vec++; if (vp_reset !== 1'b0) begin fails++; $display("FAIL rst_vp_reset_released got %b want 0", vp_reset); end
    vec++; if (host_busy !== 1'b0) begin fails++; $display("FAIL rst_busy_after got %b want 0", host_busy); end
  endtask

  task automatic test_host_write();
    logic [14:0] d [3];
    d[0] = 15'h1234; d[1] = 15'h0ABC; d[2] = 15'h7FFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      host_we = 1'b1; host_addr = 8'(i); host_din = d[i]; in_valid = (i == 2);
      #1;
      vec++;
      if (vp_we_ins_m !== 1'b1 || vp_addr_ins_m !== 8'(i) || vp_din_ins_m !== d[i]) begin
        fails++; $display("FAIL host_write%0d got we=%b a=%h d=%h want 1 %h %h", i, vp_we_ins_m, vp_addr_ins_m, vp_din_ins_m, 8'(i), d[i]);
      end
      vec++; if (host_busy !== 1'b0) begin fails++; $display("FAIL host_write_busy%0d got %b want 0", i, host_busy); end
    end
    @(negedge clk);
    host_we = 1'b0; in_valid = 1'b0;
    #1;
    vec++;
    if (host_busy !== 1'b0 || in_ready !== 1'b0 || vp_we_ins_m !== 1'b0) begin
      fails++; $display("FAIL host_wins got busy=%b rdy=%b we=%b want 000", host_busy, in_ready, vp_we_ins_m);
    end
  endtask

  // one vertex; hold = OUT cycles with out_ready low before accepting
  task automatic run_vertex(input int p, input logic [127:0] res, input logic [127:0] seed, input int hold);
    int b = 0, first_acc = -1, en_cnt = 0, en_first = -1, en_last = -1;
    int rst_cnt = 0, rst_cyc = -1, ff_cnt = 0, collide = 0, out_cyc = -1, held = 0;
    logic done = 1'b0;
    cfg_prog_len = 8'(p); res_val = res;
    for (int cyc = 0; cyc < 80 && !done; cyc++) begin
      @(negedge clk);
      in_valid  = (b < WORDS);
      in_data   = seed + 128'(b);
      out_ready = (held >= hold);
      host_we   = out_valid && hold > 0 && held == 2;
      host_addr = 8'h55; host_din = 15'h1111;
      #1;
      if (in_valid && in_ready) begin
        vec++;
        if (vp_we_inf !== 1'b1 || vp_addr_inf !== 8'(b) || vp_info_in !== in_data) begin
          fails++; $display("FAIL load_beat%0d got we=%b a=%h want 1 %h", b, vp_we_inf, vp_addr_inf, 8'(b));
        end
        if (first_acc < 0) first_acc = cyc;
        b++;
      end
      if (vp_reset) begin rst_cnt++; rst_cyc = cyc; end
      if (vp_enable) begin
        if (en_first < 0) en_first = cyc;
        en_last = cyc; en_cnt++;
      end
      if (vp_enable && vp_we_inf) collide++;
      if (vp_addr_inf == 8'hFF && !vp_we_inf) ff_cnt++;
      if (out_valid) begin
        if (out_cyc < 0) out_cyc = cyc;
        vec++; if (out_data !== res) begin fails++; $display("FAIL out_data got %h want %h", out_data, res); end
        vec++; if (in_ready !== 1'b0) begin fails++; $display("FAIL out_in_ready got %b want 0", in_ready); end
        if (host_we) begin
          vec++;
          if (vp_we_ins_m !== 1'b0 || host_busy !== 1'b1) begin
            fails++; $display("FAIL busy_host_we got we=%b busy=%b want 0 1", vp_we_ins_m, host_busy);
          end
        end
        if (out_ready) done = 1'b1;
        else held++;
      end
    end
    in_valid = 1'b0; host_we = 1'b0;
    vec++; if (!done) begin fails++; $display("FAIL vertex_timeout got no result want result p=%0d", p); end
    vec++; if (out_cyc - first_acc != WORDS + p + 3) begin fails++; $display("FAIL latency got %0d want %0d", out_cyc - first_acc, WORDS + p + 3); end
    vec++; if (en_cnt != p) begin fails++; $display("FAIL enable_cycles got %0d want %0d", en_cnt, p); end
    if (p > 0) begin
      vec++; if (en_last - en_first + 1 != p) begin fails++; $display("FAIL enable_contig got %0d want %0d", en_last - en_first + 1, p); end
      vec++; if (rst_cyc != en_first - 1) begin fails++; $display("FAIL clear_before_run got %0d want %0d", rst_cyc, en_first - 1); end
    end
    vec++; if (rst_cnt != 1) begin fails++; $display("FAIL clear_cycles got %0d want 1", rst_cnt); end
    vec++; if (ff_cnt != 2) begin fails++; $display("FAIL res_addr_cycles got %0d want 2", ff_cnt); end
    vec++; if (collide != 0) begin fails++; $display("FAIL we_enable_collide got %0d want 0", collide); end
    vec++; if (held != hold) begin fails++; $display("FAIL out_hold got %0d want %0d", held, hold); end
    exp_cnt = exp_cnt + 16'd1;
    @(negedge clk); #1;
    vec++; if (vert_count !== exp_cnt) begin fails++; $display("FAIL vert_count got %0d want %0d", vert_count, exp_cnt); end
    vec++; if (host_busy !== 1'b0 || out_valid !== 1'b0) begin fails++; $display("FAIL back_idle got busy=%b ov=%b want 00", host_busy, out_valid); end
  endtask

  task automatic test_reset_mid_run();
    int b = 0, en = 0;
    cfg_prog_len = 8'd10;
    for (int cyc = 0; cyc < 40 && en < 4; cyc++) begin
      @(negedge clk);
      in_valid = (b < WORDS);
      in_data  = 128'hDEAD_0000 + 128'(b);
      #1;
      if (in_valid && in_ready) b++;
      if (vp_enable) en++;
    end
    vec++; if (en != 4) begin fails++; $display("FAIL mid_reset_reach got %0d run cycles want 4", en); end
    reset = 1'b0;
    #1;
    vec++; if (vp_enable !== 1'b0 || vp_reset !== 1'b1) begin fails++; $display("FAIL mid_reset_halt got en=%b rst=%b want 0 1", vp_enable, vp_reset); end
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0;
    #1;
    vec++;
    if (host_busy !== 1'b0 || vp_enable !== 1'b0 || out_valid !== 1'b0 || vert_count !== 16'd0) begin
      fails++; $display("FAIL mid_reset_idle got busy=%b en=%b ov=%b cnt=%0d want 0 0 0 0", host_busy, vp_enable, out_valid, vert_count);
    end
    exp_cnt = '0;
  endtask

  initial begin
    test_reset();
    test_host_write();
    run_vertex(10, 128'hA5A5_0000_1111_2222_3333_4444_5555_6666, 128'h1000, 0);
    run_vertex(2, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 128'h2000, 5);
    run_vertex(0, 128'hCAFE_F00D, 128'h3000, 0);
    test_reset_mid_run();
    run_vertex(3, 128'h7777_8888, 128'h4000, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1);
  end

endmodule
